// File: rtl/instruction_fetch_pkg.sv
// Shared types for the fetch front end: FSM states, the buffered {pc, instr}
// entry and the word-alignment helper.
package instruction_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   localparam int unsigned INSTR_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with flush and a registered
// head entry, plus its overflow checker.
module fetch_fifo_chk (
   input logic clk,
   input logic rstf,
   input logic push,
   input logic full
);
   a_no_overflow: assert property (@(posedge clk) disable iff (!rstf) !(push && full));
endmodule

module fetch_fifo
   import instruction_fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CW    = $clog2(DEPTH + 1),
   localparam int unsigned PW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rstf,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output logic [CW-1:0] count,
   output logic         empty,
   output fetch_entry_t head
);

   fetch_entry_t      mem_q [DEPTH];
   fetch_entry_t      head_q, head_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d, remain_s;
   logic              do_pop_s, we_s, full_s;

   assign full_s = (count_q == CW'(DEPTH));
   assign count  = count_q;
   assign empty  = (count_q == CW'(0));
   assign head   = head_q;

   // The head is precomputed so the consumer only ever sees flop outputs.
   always_comb begin
      do_pop_s = pop && (count_q != CW'(0));
      remain_s = count_q - CW'(do_pop_s);
      we_s     = 1'b0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (flush) begin
         wr_ptr_d = PW'(0);
         rd_ptr_d = PW'(0);
         count_d  = CW'(0);
         head_d   = fetch_entry_t'(64'h0);
      end else begin
         we_s     = push;
         wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
         rd_ptr_d = do_pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
         count_d  = remain_s + CW'(push);
         if (remain_s != CW'(0)) begin
            head_d = mem_q[rd_ptr_d];
         end else if (push) begin
            head_d = push_data;
         end else begin
            head_d = head_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we_s) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         wr_ptr_q <= PW'(0);
         rd_ptr_q <= PW'(0);
         count_q  <= CW'(0);
         head_q   <= fetch_entry_t'(64'h0);
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   fetch_fifo_chk u_chk (
      .clk  (clk),
      .rstf (rstf),
      .push (push),
      .full (full_s)
   );

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC generation, in-order imem word reads and a buffered
// {pc, instr} stream to decode. IFETCH_PERF_CNT_EN adds fetch/stall counters.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rstf,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] i_instr,
   output logic        i_instr_valid,
   input  logic        i_instr_ready,
   output logic [31:0] oPC
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
`endif
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SW = CW + 1;

   fetch_state_t  state_q, state_d;
   logic [31:0]   req_pc_q, req_pc_d, rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
   logic [CW-1:0] drop_next_s, fifo_count_s;
   logic          fifo_empty_s, credit_ok_s, req_hs_s, push_s, pop_s;
   fetch_entry_t  fifo_head_s, push_entry_s;

   // In-flight plus buffered instructions never exceed the buffer size.
   assign credit_ok_s   = ({1'b0, outstanding_q} + {1'b0, fifo_count_s}) < SW'(FIFO_DEPTH);
   assign imem_req_addr = req_pc_q;
   assign i_instr       = fifo_head_s.instr;
   assign oPC           = fifo_head_s.pc;
   assign push_entry_s  = '{pc: rsp_pc_q, instr: imem_rsp_data};

   always_comb begin
      imem_req_valid = (state_q == FETCH) && !redirect_valid && credit_ok_s;
      req_hs_s       = imem_req_valid && imem_req_ready;
      i_instr_valid  = !fifo_empty_s && !redirect_valid;
      pop_s          = i_instr_valid && i_instr_ready;
      push_s         = imem_rsp_valid && (drop_cnt_q == CW'(0)) && !redirect_valid;
      if (imem_rsp_valid && (outstanding_q != CW'(0))) begin
         drop_next_s = outstanding_q - CW'(1);
      end else begin
         drop_next_s = outstanding_q;
      end
      outstanding_d = outstanding_q + CW'(req_hs_s) - CW'(imem_rsp_valid);
      req_pc_d      = req_hs_s ? req_pc_q + 32'(INSTR_BYTES) : req_pc_q;
      rsp_pc_d      = push_s ? rsp_pc_q + 32'(INSTR_BYTES) : rsp_pc_q;
      if (imem_rsp_valid && (drop_cnt_q != CW'(0))) begin
         drop_cnt_d = drop_cnt_q - CW'(1);
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
      state_d = state_q;
      case (state_q)
         IDLE:  state_d = FETCH;
         FETCH: begin
            if (redirect_valid && (drop_next_s != CW'(0))) begin
               state_d    = DRAIN;
               drop_cnt_d = drop_next_s;
            end else begin
               state_d = FETCH;
            end
         end
         // A redirect here only moves the PC: everything in flight is already stale.
         DRAIN: state_d = (drop_cnt_d == CW'(0)) ? FETCH : DRAIN;
         default: state_d = IDLE;
      endcase
      if (redirect_valid) begin
         req_pc_d = align_word(redirect_pc);
         rsp_pc_d = align_word(redirect_pc);
      end else begin
         req_pc_d = req_pc_d;
      end
   end

   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         state_q       <= IDLE;
         req_pc_q      <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= CW'(0);
         drop_cnt_q    <= CW'(0);
      end else begin
         state_q       <= state_d;
         req_pc_q      <= req_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rstf      (rstf),
      .push      (push_s),
      .push_data (push_entry_s),
      .pop       (pop_s),
      .flush     (redirect_valid),
      .count     (fifo_count_s),
      .empty     (fifo_empty_s),
      .head      (fifo_head_s)
   );

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_fetched_d, perf_stall_q, perf_stall_d;

   always_comb begin
      perf_fetched_d = pop_s ? perf_fetched_q + 32'd1 : perf_fetched_q;
      if ((state_q == FETCH) && !imem_req_valid && !redirect_valid) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end else begin
         perf_stall_d = perf_stall_q;
      end
   end

   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         perf_fetched_q <= 32'h0;
         perf_stall_q   <= 32'h0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_stall_q   <= perf_stall_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`endif

endmodule
